// File: rtl/spi_pkg.sv
// Shared definitions for the SPI sequencer/arbiter: FSM encoding and byte-count limits.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int SPI_MAX_BYTES = 4;
  localparam int NB_W          = 3;

  function automatic logic nbytes_legal(input logic [NB_W-1:0] n);
    return (n != '0) && (n <= NB_W'(SPI_MAX_BYTES));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: highest priority at ptr, then ptr+1 .. wrapping mod N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner
);

  logic found;
  int   idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPIMaster between N_REQ requesters: round-robin grant, sequenced SS/enable,
// completion capture and watchdog abort. All outputs registered.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int SS_ACTIVE_HIGH = 0,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [N_REQ-1:0]      req_i,
  input  logic [32*N_REQ-1:0]   wdata_i,
  input  logic [3*N_REQ-1:0]    nbytes_i,
  output logic [N_REQ-1:0]      gnt_o,
  output logic [N_REQ-1:0]      done_o,
  output logic [N_REQ-1:0]      err_o,
  output logic [31:0]           rdata_o,
  output logic [N_REQ-1:0]      spi_ss_o,
  output logic                  spi_enable_o,
  output logic [31:0]           spi_wdata_o,
  output logic [NB_W-1:0]       spi_nbytes_o,
  input  logic [31:0]           spi_rdata_i,
  input  logic [NB_W-1:0]       spi_rbytes_i,
  input  logic                  spi_ready_i
);

  localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [N_REQ-1:0] SS_IDLE = (SS_ACTIVE_HIGH != 0) ? {N_REQ{1'b0}} : {N_REQ{1'b1}};
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit               WD_EN   = (TIMEOUT_CYCLES != 0);

  state_e              state_q;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [WD_W-1:0]     wdog_q;
  logic [N_REQ-1:0]    gnt_q, done_q, err_q, ss_q;
  logic [31:0]         rdata_q, wdata_q;
  logic [NB_W-1:0]     nbytes_q;
  logic                en_q;

  logic [N_REQ-1:0]    winner;
  logic [PW-1:0]       win_idx;
  logic [31:0]         win_wdata;
  logic [NB_W-1:0]     win_nbytes;
  logic                wd_expired;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
    .req    (req_i),
    .ptr    (ptr_q),
    .winner (winner)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner[i]) win_idx = PW'(i);
    end
    win_wdata  = wdata_i[32*win_idx +: 32];
    win_nbytes = nbytes_i[3*win_idx +: 3];
    ptr_d      = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
  end

  // Once past the limit the count stays expired, so a transfer that completes XFER
  // on its final allowed cycle still times out in DRAIN unless ready is already up.
  assign wd_expired = WD_EN && (wdog_q >= WD_LAST);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      wdog_q   <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      ss_q     <= SS_IDLE;
      rdata_q  <= '0;
      wdata_q  <= '0;
      nbytes_q <= '0;
      en_q     <= 1'b0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|req_i && spi_ready_i) begin
            ptr_q <= ptr_d;
            if (nbytes_legal(win_nbytes)) begin
              wdata_q  <= win_wdata;
              nbytes_q <= win_nbytes;
              gnt_q    <= winner;
              ss_q     <= SS_IDLE ^ winner;
              wdog_q   <= '0;
              state_q  <= ST_SETUP;
            end else begin
              err_q <= winner;
            end
          end
        end
        ST_SETUP: begin
          en_q    <= 1'b1;
          state_q <= ST_XFER;
        end
        ST_XFER: begin
          wdog_q <= wdog_q + WD_W'(1);
          if (spi_rbytes_i == nbytes_q) begin
            en_q    <= 1'b0;
            state_q <= ST_DRAIN;
          end else if (wd_expired) begin
            en_q    <= 1'b0;
            ss_q    <= SS_IDLE;
            gnt_q   <= '0;
            err_q   <= gnt_q;
            state_q <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          wdog_q <= wdog_q + WD_W'(1);
          if (spi_ready_i) begin
            rdata_q <= spi_rdata_i;
            done_q  <= gnt_q;
            gnt_q   <= '0;
            ss_q    <= SS_IDLE;
            state_q <= ST_IDLE;
          end else if (wd_expired) begin
            ss_q    <= SS_IDLE;
            gnt_q   <= '0;
            err_q   <= gnt_q;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt_o        = gnt_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign rdata_o      = rdata_q;
  assign spi_ss_o     = ss_q;
  assign spi_enable_o = en_q;
  assign spi_wdata_o  = wdata_q;
  assign spi_nbytes_o = nbytes_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter (4 requesters, active-low SS, 16-cycle watchdog).
module tb_spi_arbiter;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [3:0]    req;
  logic [127:0]  wdata;
  logic [11:0]   nbytes;
  logic [3:0]    gnt, done, err, ss;
  logic [31:0]   rdata, spi_wdata, spi_rdata;
  logic          spi_en, spi_ready;
  logic [2:0]    spi_nbytes, spi_rbytes;

  int total = 0;
  int bad   = 0;

  spi_arbiter #(.N_REQ(4), .SS_ACTIVE_HIGH(0), .TIMEOUT_CYCLES(16)) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .req_i        (req),
    .wdata_i      (wdata),
    .nbytes_i     (nbytes),
    .gnt_o        (gnt),
    .done_o       (done),
    .err_o        (err),
    .rdata_o      (rdata),
    .spi_ss_o     (ss),
    .spi_enable_o (spi_en),
    .spi_wdata_o  (spi_wdata),
    .spi_nbytes_o (spi_nbytes),
    .spi_rdata_i  (spi_rdata),
    .spi_rbytes_i (spi_rbytes),
    .spi_ready_i  (spi_ready)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(negedge HCLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt();
    int n = 0;
    while (gnt === 4'h0 && n < 20) begin
      tick();
      n++;
    end
    chk("gnt_wait_bound", 32'(n < 20), 32'd1);
  endtask

  // Entered in the SETUP cycle; returns in the done cycle.
  task automatic do_xfer(input logic [2:0] nb, input logic [31:0] rd);
    tick();
    chk("x_en_high", 32'(spi_en), 32'd1);
    spi_rbytes = nb;
    spi_ready  = 1'b0;
    tick();
    chk("x_en_low_drain", 32'(spi_en), 32'd0);
    spi_ready  = 1'b1;
    spi_rdata  = rd;
    spi_rbytes = 3'd0;
    tick();
  endtask

  initial begin
    HRESET = 1'b1; req = '0; wdata = '0; nbytes = '0;
    spi_rdata = '0; spi_rbytes = '0; spi_ready = 1'b1;
    tick(); tick();
    chk("rst_gnt",    32'(gnt), 32'h0);
    chk("rst_done",   32'(done), 32'h0);
    chk("rst_err",    32'(err), 32'h0);
    chk("rst_rdata",  rdata, 32'h0);
    chk("rst_en",     32'(spi_en), 32'h0);
    chk("rst_wdata",  spi_wdata, 32'h0);
    chk("rst_nbytes", 32'(spi_nbytes), 32'h0);
    chk("rst_ss",     32'(ss), 32'hF);
    HRESET = 1'b0;

    // single transfer, requester 0, two bytes
    req = 4'b0001; wdata[31:0] = 32'hA5C3_0F12; nbytes[2:0] = 3'd2;
    tick();
    chk("s_gnt",    32'(gnt), 32'h1);
    chk("s_ss",     32'(ss), 32'hE);
    chk("s_en_setup", 32'(spi_en), 32'h0);
    chk("s_wdata",  spi_wdata, 32'hA5C3_0F12);
    chk("s_nbytes", 32'(spi_nbytes), 32'h2);
    req = 4'b0000;
    tick();
    chk("s_en_xfer", 32'(spi_en), 32'h1);
    spi_rbytes = 3'd1; spi_ready = 1'b0;
    tick();
    chk("s_en_partial", 32'(spi_en), 32'h1);
    spi_rbytes = 3'd2;
    tick();
    chk("s_en_drop", 32'(spi_en), 32'h0);
    chk("s_ss_drain", 32'(ss), 32'hE);
    spi_rbytes = 3'd0;
    tick();
    chk("s_drain_wait_done", 32'(done), 32'h0);
    chk("s_drain_wait_gnt",  32'(gnt), 32'h1);
    spi_rdata = 32'h0000_BEEF; spi_ready = 1'b1;
    tick();
    chk("s_done",  32'(done), 32'h1);
    chk("s_rdata", rdata, 32'h0000_BEEF);
    chk("s_ss_off", 32'(ss), 32'hF);
    chk("s_gnt_off", 32'(gnt), 32'h0);
    tick();
    chk("s_done_pulse", 32'(done), 32'h0);

    // fairness from a reset pointer
    HRESET = 1'b1; tick(); HRESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wdata[32*i +: 32] = 32'h1111_1111 * (i + 1);
      nbytes[3*i +: 3]  = 3'd1;
    end
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      wait_gnt();
      chk("f_gnt",   32'(gnt), 32'(1 << (k % 4)));
      chk("f_wdata", spi_wdata, 32'h1111_1111 * ((k % 4) + 1));
      do_xfer(3'd1, 32'h100 + k);
      chk("f_done",  32'(done), 32'(1 << (k % 4)));
      chk("f_gnt_clear_at_done", 32'(gnt), 32'h0);
      chk("f_rdata", rdata, 32'h100 + k);
    end
    req = 4'b0000;
    tick(); tick();

    // illegal byte counts on requester 2
    nbytes[8:6] = 3'd0; req = 4'b0100;
    tick();
    chk("i0_err", 32'(err), 32'h4);
    chk("i0_gnt", 32'(gnt), 32'h0);
    chk("i0_ss",  32'(ss), 32'hF);
    req = 4'b0000;
    tick();
    chk("i0_err_pulse", 32'(err), 32'h0);
    chk("i0_en", 32'(spi_en), 32'h0);
    nbytes[8:6] = 3'd5; req = 4'b0100;
    tick();
    chk("i5_err", 32'(err), 32'h4);
    chk("i5_ss",  32'(ss), 32'hF);
    req = 4'b0000;
    tick();
    chk("i5_en", 32'(spi_en), 32'h0);
    nbytes[11:9] = 3'd4; wdata[127:96] = 32'hCAFE_F00D; req = 4'b1001;
    tick();
    chk("ptr3_gnt", 32'(gnt), 32'h8);
    chk("ptr3_wdata", spi_wdata, 32'hCAFE_F00D);
    req = 4'b0000;
    do_xfer(3'd4, 32'hDEAD_BEEF);
    chk("ptr3_done",  32'(done), 32'h8);
    chk("ptr3_rdata", rdata, 32'hDEAD_BEEF);
    tick();

    // watchdog on requester 1: rbytes stalls at 1 of 3
    nbytes[5:3] = 3'd3; req = 4'b0010;
    tick();
    chk("w_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick();
    chk("w_en", 32'(spi_en), 32'h1);
    spi_rbytes = 3'd1; spi_ready = 1'b0;
    for (int c = 1; c < 16; c++) begin
      tick();
      chk("w_hold_en",  32'(spi_en), 32'h1);
      chk("w_hold_err", 32'(err), 32'h0);
    end
    tick();
    chk("w_err",   32'(err), 32'h2);
    chk("w_en_off", 32'(spi_en), 32'h0);
    chk("w_ss_off", 32'(ss), 32'hF);
    chk("w_gnt_off", 32'(gnt), 32'h0);
    chk("w_no_done", 32'(done), 32'h0);
    chk("w_rdata_kept", rdata, 32'hDEAD_BEEF);
    spi_rbytes = 3'd0; spi_ready = 1'b1;
    tick();
    chk("w_err_pulse", 32'(err), 32'h0);

    // reset during XFER on requester 2, completion presented at the same edge
    nbytes[8:6] = 3'd1; req = 4'b0100;
    tick();
    chk("r_gnt", 32'(gnt), 32'h4);
    req = 4'b0000;
    tick();
    chk("r_en", 32'(spi_en), 32'h1);
    HRESET = 1'b1; spi_rbytes = 3'd1;
    tick();
    chk("r_en_off", 32'(spi_en), 32'h0);
    chk("r_ss_off", 32'(ss), 32'hF);
    chk("r_gnt_off", 32'(gnt), 32'h0);
    chk("r_no_done", 32'(done), 32'h0);
    chk("r_no_err",  32'(err), 32'h0);
    chk("r_rdata",   rdata, 32'h0);
    HRESET = 1'b0; spi_rbytes = 3'd0;
    tick();
    chk("r_idle_en", 32'(spi_en), 32'h0);
    req = 4'b1000;
    tick();
    chk("r_first_gnt", 32'(gnt), 32'h8);
    chk("r_first_ss",  32'(ss), 32'h7);
    req = 4'b0000;
    do_xfer(3'd4, 32'h1234_5678);
    chk("r_done", 32'(done), 32'h8);
    tick();

    // ready gating on requester 1
    spi_ready = 1'b0; nbytes[5:3] = 3'd3; req = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("g_no_gnt", 32'(gnt), 32'h0);
      chk("g_no_err", 32'(err), 32'h0);
    end
    spi_ready = 1'b1;
    tick();
    chk("g_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    do_xfer(3'd3, 32'h00AB_CDEF);
    chk("g_done",  32'(done), 32'h2);
    chk("g_rdata", rdata, 32'h00AB_CDEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Sequencer and round-robin arbiter that shares one `SPIMaster` core between `N_REQ` requesters, each owning a dedicated slave-select line. It sits between on-chip SPI clients (AHB peripheral bridge, accelerator config loaders) and the `SPIMaster` enable/ready datapath. It latches a winner's write word and byte count, then drives that slave select and the master's enable for exactly the requested bytes. It returns the received word with a one-cycle done pulse, and aborts hung transfers on a watchdog.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `SS_ACTIVE_HIGH`, 0: 1 means slave selects are active-high; 0 means active-low.
- `TIMEOUT_CYCLES`, 4096: watchdog limit for XFER+DRAIN; 0 disables the watchdog.
- `HCLK`  in  1  system clock; single clock domain.
- `HRESET`  in  1  reset, synchronous, active-high.
- `req_i`  in  N_REQ  per-requester transfer request, level.
- `wdata_i`  in  32*N_REQ  requester i word at `[32*i +: 32]`.
- `nbytes_i`  in  3*N_REQ  requester i byte count at `[3*i +: 3]`; legal range 1..4.
- `gnt_o`  out  N_REQ  one-hot grant.
- `done_o`  out  N_REQ  one-cycle completion pulse.
- `err_o`  out  N_REQ  one-cycle pulse on illegal `nbytes` or watchdog abort.
- `rdata_o`  out  32  received word; valid with `done_o`, held until the next done.
- `spi_ss_o`  out  N_REQ  slave selects.
- `spi_enable_o`  out  1  drives `SPIMaster.enable_i`.
- `spi_wdata_o`  out  32  drives `SPIMaster.spi_write_data_i`.
- `spi_nbytes_o`  out  3  drives `SPIMaster.spi_write_data_bytes_valid_i`.
- `spi_rdata_i`  in  32  from `SPIMaster.spi_read_data_o`.
- `spi_rbytes_i`  in  3  from `SPIMaster.spi_read_data_bytes_valid_o`.
- `spi_ready_i`  in  1  from `SPIMaster.ready_o`.

## Operation
- **Requester rule:** hold `req_i`, `wdata_i` and `nbytes_i` stable until `gnt_o[i]`. After `done_o` or `err_o`, keep `req_i` low for at least one cycle unless a new transfer is wanted; `req_i` still high at that point is a new request.
- **States:** IDLE, SETUP, XFER, DRAIN.
- **IDLE:**
  - If any `req_i` is high and `spi_ready_i` is high, pick a winner round-robin. Priority starts at `ptr` and runs to `ptr+1` .. mod `N_REQ`.
  - Legal `nbytes` (1..4): latch `wdata` to `spi_wdata_o` and `nbytes` to `spi_nbytes_o`, set `gnt_o`, assert `spi_ss_o[i]`, go to SETUP.
  - Illegal `nbytes` (0, 5-7): pulse `err_o[i]`, stay in IDLE.
  - In both cases `ptr` becomes winner+1 mod `N_REQ`.
- **SETUP:** one cycle of SS setup with enable low, then go to XFER.
- **XFER:** `spi_enable_o`=1. When `spi_rbytes_i` equals the latched `spi_nbytes_o`, drop enable and go to DRAIN.
- **DRAIN:** wait for `spi_ready_i`=1. Then capture `spi_rdata_i` into `rdata_o`, pulse `done_o[i]`, clear `gnt_o` and SS, and go to IDLE.
- **Watchdog:**
  - The counter clears on entry to SETUP and increments each cycle in XFER/DRAIN.
  - When it reaches `TIMEOUT_CYCLES`: drop enable, SS and grant; pulse `err_o[i]`; leave `rdata_o` unchanged; go to IDLE.
- **Ordering:** `done_o`/`err_o` are never issued in the same cycle as a new grant. IDLE spends at least one cycle before re-arbitrating.

## Timing
- All outputs are registered.
- **Reset values:**
  - `gnt_o`, `done_o`, `err_o`, `rdata_o`, `spi_enable_o`, `spi_wdata_o`, `spi_nbytes_o` = 0.
  - `spi_ss_o` = all inactive: all 0 if `SS_ACTIVE_HIGH`, otherwise all 1.
  - `ptr` = 0, state = IDLE.
- **Grant and transfer latency:**
  - `req_i` sampled at edge t in IDLE: `gnt_o` and SS are active from t+1.
  - `spi_enable_o` is high from t+2.
  - The last enable-high cycle is the one in which `spi_rbytes_i`==nbytes is sampled.
- **Completion:** `spi_ready_i` sampled high in DRAIN at edge d. In cycle d+1, `done_o` is high, `rdata_o` is valid, SS is inactive and `gnt_o`=0.
- **Illegal byte count:** `err_o` is high in the cycle after sampling.
- **Reset mid-transfer:** `HRESET` wins over all other events. At the next edge all outputs take reset values, with no `done_o`/`err_o` pulse.
- **Master not ready:** `spi_ready_i` low in IDLE blocks arbitration; requests wait without error.
- **Simultaneous events:** a watchdog expiry in the same cycle as completion or `spi_ready_i` resolves as completion.

## Structure
- Shared package `spi_pkg`:
  - state encoding (IDLE/SETUP/XFER/DRAIN);
  - `SPI_MAX_BYTES`=4;
  - byte-count width 3.
- Sub-module `rr_arbiter` (parameter `N`): inputs `req`, `ptr`; output one-hot `winner`. Purely combinational.
- The top level holds the FSM, latches, pointer and watchdog.

## Test plan
- **Single transfer:** req[0], wdata=32'hA5C3_0F12, nbytes=2; SPI model returns 16'hBEEF. Expect enable high exactly until rbytes==2, done_o[0] one cycle, rdata_o[15:0]=16'hBEEF, ss[0] active only between grant and done.
- **Fairness:** all four req held high continuously with nbytes=1. Grants occur in order 0,1,2,3,0,1; no requester waits more than 3 transfers.
- **Illegal size:** req[2] with nbytes=0, then nbytes=5. Expect err_o[2] pulse each time, no SS or enable activity, and ptr=3 afterwards.
- **Watchdog:** TIMEOUT_CYCLES=16, SPI model never advances rbytes. Expect err_o[1] at 16 cycles after entering XFER, enable/SS/grant dropped, and rdata_o unchanged.
- **Reset mid-transfer:** HRESET asserted during XFER. Next cycle: enable=0, all SS inactive, gnt=0, no done; after release, req[3] gets a clean first grant from ptr=0.
- **Ready gating:** spi_ready_i held low for 10 cycles with req[1] high. No grant during those 10 cycles; gnt_o[1] the cycle after ready rises.
